// File: rtl/br_pred_unit.sv
// br_pred_unit: fetch PC register with direct-mapped BTB prediction and EX-stage branch/jump resolution.
module br_pred_unit #(
    parameter int XLEN = 32,
    parameter int BTB_DEPTH = 16,
    parameter int CTR_BITS = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_br,
    input  logic [2:0]      ex_br_op,
    input  logic            ex_is_j,
    input  logic            ex_is_jr,
    input  logic [25:0]     ex_instr_index,
    input  logic [15:0]     ex_offset,
    input  logic [XLEN-1:0] ex_rs,
    input  logic [XLEN-1:0] ex_rt,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     mispred_cnt
);
    localparam int IW = $clog2(BTB_DEPTH);
    localparam int TW = XLEN - IW - 2;
    localparam logic [CTR_BITS-1:0] WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [BTB_DEPTH-1:0] valid;
    logic [TW-1:0]        tags    [BTB_DEPTH];
    logic [XLEN-1:0]      targets [BTB_DEPTH];
    logic [CTR_BITS-1:0]  ctrs    [BTB_DEPTH];

    logic [IW-1:0]   idx, ex_idx;
    logic [TW-1:0]   ex_tag;
    logic            hit, ex_hit, upd, cond, sign, zero, actual_taken;
    logic [XLEN-1:0] br_target, j_target, actual_target, ex_pc4;

    assign idx         = pc[IW+1:2];
    assign hit         = valid[idx] && tags[idx] == pc[XLEN-1:IW+2];
    assign pred_taken  = hit && ctrs[idx][CTR_BITS-1];
    assign pred_target = pred_taken ? targets[idx] : pc + XLEN'(4);

    assign ex_idx    = ex_pc[IW+1:2];
    assign ex_tag    = ex_pc[XLEN-1:IW+2];
    assign ex_hit    = valid[ex_idx] && tags[ex_idx] == ex_tag;
    assign ex_pc4    = ex_pc + XLEN'(4);
    assign br_target = ex_pc4 + {{(XLEN-18){ex_offset[15]}}, ex_offset, 2'b00};
    assign j_target  = {ex_pc[XLEN-1:28], ex_instr_index, 2'b00};
    assign sign      = ex_rs[XLEN-1];
    assign zero      = ex_rs == '0;

    always_comb begin
        cond = ex_br_op == 3'd0 ? ex_rs == ex_rt :
               ex_br_op == 3'd1 ? ex_rs != ex_rt :
               ex_br_op == 3'd2 ? sign | zero :
               ex_br_op == 3'd3 ? !sign && !zero :
               ex_br_op == 3'd4 ? sign :
               ex_br_op == 3'd5 ? !sign : 1'b0;
        actual_taken  = ex_is_j | ex_is_jr | (ex_is_br & cond);
        actual_target = ex_is_jr ? ex_rs : ex_is_j ? j_target : br_target;
        redirect      = ex_valid && (actual_taken != ex_pred_taken ||
                        (actual_taken && actual_target != ex_pred_target));
        redirect_pc   = actual_taken ? actual_target : ex_pc4;
    end

    assign upd = ex_valid & (ex_is_br | ex_is_j | ex_is_jr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            mispred_cnt <= '0;
        end else begin
            pc <= redirect ? redirect_pc : stall ? pc : pred_target;
            if (redirect && !(&mispred_cnt))
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    // Lookup reads the arrays combinationally, so same-cycle updates are seen only next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                tags[i]    <= '0;
                targets[i] <= '0;
                ctrs[i]    <= '0;
            end
        end else if (upd) begin
            if (ex_hit) begin
                if (actual_taken) begin
                    targets[ex_idx] <= actual_target;
                    if (!(&ctrs[ex_idx]))
                        ctrs[ex_idx] <= ctrs[ex_idx] + CTR_BITS'(1);
                end else if (|ctrs[ex_idx]) begin
                    ctrs[ex_idx] <= ctrs[ex_idx] - CTR_BITS'(1);
                end
            end else if (actual_taken) begin
                valid[ex_idx]   <= 1'b1;
                tags[ex_idx]    <= ex_tag;
                targets[ex_idx] <= actual_target;
                ctrs[ex_idx]    <= ex_is_br ? WEAK : '1;
            end
        end
    end
endmodule

// File: tb/tb_br_pred_unit.sv
// tb_br_pred_unit: directed checks of PC sequencing, BTB training/aliasing, resolution and mispredict counting.
module tb_br_pred_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] pc, pred_target, redirect_pc, mispred_cnt;
    logic        pred_taken, redirect;
    logic        ex_valid = 1'b0, ex_is_br = 1'b0, ex_is_j = 1'b0, ex_is_jr = 1'b0;
    logic        ex_pred_taken = 1'b0;
    logic [2:0]  ex_br_op = 3'd0;
    logic [31:0] ex_pc = '0, ex_rs = '0, ex_rt = '0, ex_pred_target = '0;
    logic [25:0] ex_instr_index = '0;
    logic [15:0] ex_offset = '0;
    int checks = 0;
    int failures = 0;

    br_pred_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .pc(pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_br(ex_is_br), .ex_br_op(ex_br_op),
        .ex_is_j(ex_is_j), .ex_is_jr(ex_is_jr), .ex_instr_index(ex_instr_index),
        .ex_offset(ex_offset), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect(redirect), .redirect_pc(redirect_pc), .mispred_cnt(mispred_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic br, input logic j, input logic jr, input logic [2:0] op,
                      input logic [31:0] epc, input logic [15:0] off, input logic [25:0] index,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic ptk, input logic [31:0] ptg);
        ex_valid = 1'b1; ex_is_br = br; ex_is_j = j; ex_is_jr = jr; ex_br_op = op;
        ex_pc = epc; ex_offset = off; ex_instr_index = index; ex_rs = rs; ex_rt = rt;
        ex_pred_taken = ptk; ex_pred_target = ptg;
    endtask

    // Non-branch EX instruction carrying a false taken prediction: redirects to a, leaves BTB alone.
    task automatic go(input logic [31:0] a);
        ex(1'b0, 1'b0, 1'b0, 3'd0, a - 32'd4, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, a);
        tick;
        ex_valid = 1'b0;
    endtask

    initial begin
        tick;
        chk("reset_pc", pc, 32'h0);
        chk("reset_pred", pred_taken, 1'b0);
        chk("reset_cnt", mispred_cnt, 32'd0);
        chk("reset_redirect", redirect, 1'b0);
        rst = 1'b0;
        tick; chk("seq_pc4", pc, 32'h4);
        tick; chk("seq_pc8", pc, 32'h8);
        tick; chk("seq_pc12", pc, 32'hC);
        chk("seq_pred", pred_taken, 1'b0);
        #3 rst = 1'b1;
        #1 chk("async_rst_pc", pc, 32'h0);
        rst = 1'b0;
        tick; chk("after_rst_pc", pc, 32'h4);

        ex(1'b1, 1'b0, 1'b0, 3'd0, 32'h40, 16'd3, 26'd0, 32'd5, 32'd5, 1'b0, 32'h0);
        #1 chk("beq_redirect", redirect, 1'b1);
        chk("beq_redirect_pc", redirect_pc, 32'h50);
        tick; ex_valid = 1'b0;
        chk("beq_pc", pc, 32'h50);
        chk("beq_cnt", mispred_cnt, 32'd1);
        go(32'h40);
        chk("btb_pred_taken", pred_taken, 1'b1);
        chk("btb_pred_target", pred_target, 32'h50);

        ex(1'b1, 1'b0, 1'b0, 3'd0, 32'h40, 16'd3, 26'd0, 32'd5, 32'd5, 1'b1, 32'h50);
        #1 chk("beq_correct_pred", redirect, 1'b0);
        tick;
        ex(1'b1, 1'b0, 1'b0, 3'd0, 32'h40, 16'd3, 26'd0, 32'd5, 32'd6, 1'b1, 32'h50);
        #1 chk("beq_nt_redirect", redirect, 1'b1);
        chk("beq_nt_redirect_pc", redirect_pc, 32'h44);
        tick; ex_valid = 1'b0;
        go(32'h40);
        chk("ctr10_pred", pred_taken, 1'b1);
        ex(1'b1, 1'b0, 1'b0, 3'd0, 32'h40, 16'd3, 26'd0, 32'd5, 32'd6, 1'b1, 32'h50);
        tick; ex_valid = 1'b0;
        go(32'h40);
        chk("ctr01_pred", pred_taken, 1'b0);
        chk("ctr01_target", pred_target, 32'h44);
        chk("cnt_six", mispred_cnt, 32'd6);

        ex(1'b1, 1'b0, 1'b0, 3'd4, 32'h200, 16'd1, 26'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h0);
        #1 chk("bltz_neg", redirect, 1'b1);
        chk("bltz_neg_pc", redirect_pc, 32'h208);
        ex(1'b1, 1'b0, 1'b0, 3'd3, 32'h200, 16'd1, 26'd0, 32'd0, 32'd0, 1'b0, 32'h0);
        #1 chk("bgtz_zero", redirect, 1'b0);
        chk("bgtz_zero_pc", redirect_pc, 32'h204);
        ex(1'b1, 1'b0, 1'b0, 3'd4, 32'h200, 16'd1, 26'd0, 32'h8000_0000, 32'd0, 1'b0, 32'h0);
        #1 chk("bltz_min", redirect, 1'b1);
        ex(1'b1, 1'b0, 1'b0, 3'd1, 32'h200, 16'd1, 26'd0, 32'd1, 32'd2, 1'b0, 32'h0);
        #1 chk("bne_taken", redirect, 1'b1);
        ex(1'b1, 1'b0, 1'b0, 3'd2, 32'h200, 16'd1, 26'd0, 32'd0, 32'd0, 1'b0, 32'h0);
        #1 chk("blez_zero", redirect, 1'b1);
        ex(1'b1, 1'b0, 1'b0, 3'd5, 32'h200, 16'd1, 26'd0, 32'h8000_0000, 32'd0, 1'b0, 32'h0);
        #1 chk("bgez_neg", redirect, 1'b0);
        ex(1'b1, 1'b0, 1'b0, 3'd6, 32'h200, 16'd1, 26'd0, 32'd0, 32'd0, 1'b0, 32'h0);
        #1 chk("op6_never", redirect, 1'b0);
        ex(1'b1, 1'b0, 1'b0, 3'd0, 32'h200, 16'hFFFF, 26'd0, 32'd7, 32'd7, 1'b0, 32'h0);
        #1 chk("beq_neg_off", redirect_pc, 32'h200);
        ex(1'b1, 1'b0, 1'b0, 3'd0, 32'h200, 16'd1, 26'd0, 32'd7, 32'd7, 1'b1, 32'h300);
        #1 chk("wrong_target", redirect, 1'b1);
        ex(1'b0, 1'b1, 1'b0, 3'd0, 32'hF000_0010, 16'd0, 26'd1, 32'd0, 32'd0, 1'b0, 32'h0);
        #1 chk("j_upper_bits", redirect_pc, 32'hF000_0004);
        ex_valid = 1'b0;
        #1 chk("invalid_no_redirect", redirect, 1'b0);
        tick;

        ex(1'b1, 1'b0, 1'b0, 3'd0, 32'h40, 16'd3, 26'd0, 32'd5, 32'd5, 1'b0, 32'h0);
        tick; ex_valid = 1'b0;
        go(32'h40);
        chk("retrain_pred", pred_taken, 1'b1);
        ex(1'b0, 1'b1, 1'b0, 3'd0, 32'h80, 16'd0, 26'h300, 32'd0, 32'd0, 1'b0, 32'h0);
        #1 chk("j_redirect_pc", redirect_pc, 32'hC00);
        tick; ex_valid = 1'b0;
        chk("j_pc", pc, 32'hC00);
        go(32'h40);
        chk("alias_evicted", pred_taken, 1'b0);
        chk("alias_target", pred_target, 32'h44);
        go(32'h80);
        chk("alias_new_pred", pred_taken, 1'b1);
        chk("alias_new_target", pred_target, 32'hC00);

        ex(1'b0, 1'b0, 1'b1, 3'd0, 32'h100, 16'd0, 26'd0, 32'h2000, 32'd0, 1'b1, 32'h1FFC);
        stall = 1'b1;
        #1 chk("jr_redirect", redirect, 1'b1);
        chk("jr_redirect_pc", redirect_pc, 32'h2000);
        tick; ex_valid = 1'b0;
        chk("jr_over_stall", pc, 32'h2000);
        tick;
        chk("stall_hold", pc, 32'h2000);
        stall = 1'b0;
        chk("cnt_twelve", mispred_cnt, 32'd12);

        force dut.mispred_cnt = 32'hFFFF_FFFE;
        #1 release dut.mispred_cnt;
        go(32'h300);
        chk("cnt_reach_max", mispred_cnt, 32'hFFFF_FFFF);
        go(32'h400);
        chk("cnt_saturate", mispred_cnt, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/br_pred_unit.md
Name: br_pred_unit

Overview:
Parametrised next-PC and branch unit for the MIPS pipeline. It owns the fetch PC register and predicts taken branches and jumps from a direct-mapped branch target buffer (BTB) with saturating counters. It resolves beq/bne/blez/bgtz/bltz/bgez/j/jal/jr in EX and issues a redirect and flush on misprediction. It sits between IF (consumes pc, pred_*) and EX (drives ex_*).

Parameters:
XLEN, 32, datapath/PC width (≥32)
BTB_DEPTH, 16, BTB entries; power of 2, ≥2
CTR_BITS, 2, saturating counter width (≥1)
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
stall  in  1  hold pc (IF stall)
pc  out  XLEN  current fetch PC (registered)
pred_taken  out  1  BTB predicts taken for pc (combinational)
pred_target  out  XLEN  predicted target for pc (combinational)
ex_valid  in  1  EX holds a valid instruction
ex_pc  in  XLEN  PC of EX instruction
ex_is_br  in  1  conditional branch
ex_br_op  in  3  000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz, 101 bgez, 11x never taken
ex_is_j  in  1  j/jal
ex_is_jr  in  1  jr/jalr
ex_instr_index  in  26  j-type index
ex_offset  in  16  branch offset
ex_rs  in  XLEN  rs operand (signed compare; jr target)
ex_rt  in  XLEN  rt operand
ex_pred_taken  in  1  prediction carried with EX instr
ex_pred_target  in  XLEN  prediction carried with EX instr
redirect  out  1  mispredict: flush IF/ID (combinational)
redirect_pc  out  XLEN  correct next PC
mispred_cnt  out  32  saturating mispredict count (registered)

Behaviour:
- Reset (async): pc=RESET_PC, all BTB valid=0, counters=0, mispred_cnt=0. Combinational outputs settle from reset state: pred_taken=0.
- Lookup: idx=pc[log2(BTB_DEPTH)+1:2], tag=pc[XLEN-1:log2(BTB_DEPTH)+2]. hit=valid[idx]&tag match. pred_taken=hit & ctr MSB. pred_target=entry target when pred_taken, else pc+4.
- Resolve (ex_valid only):
  - Branch target=ex_pc+4+(sext(offset)<<2).
  - j target={ex_pc[31:28],index,2'b00}.
  - jr target=ex_rs.
  - Conditions use signed ex_rs: beq rs==rt, bne rs!=rt, blez ≤0, bgtz >0, bltz <0, bgez ≥0.
  - actual_taken=j|jr|(br&cond). Flags mutually exclusive; if none set, actual_taken=0.
- redirect=ex_valid & (actual_taken!=ex_pred_taken | (actual_taken & actual_target!=ex_pred_target)).
- redirect_pc=actual_taken ? actual_target : ex_pc+4.
- PC register each posedge, priority high to low: redirect→redirect_pc (overrides stall); stall→hold; pred_taken→pred_target; else pc+4. Wraps modulo 2^XLEN.
- BTB update at posedge when ex_valid&(br|j|jr), indexed by ex_pc:
  - Hit: target<=actual_target when taken. Counter saturating +1 if taken, -1 if not. Min 0, max 2^CTR_BITS-1.
  - Miss and taken: allocate (valid=1, tag, target). Counter = max for j/jr; 10..0 (weak taken) for branches.
  - Miss and not taken: no write.
  - Update occurs regardless of stall.
- Same-cycle lookup and update to the same index: lookup sees pre-update contents.
- mispred_cnt += 1 per redirect cycle, saturates at 32'hFFFF_FFFF.
- Latency: redirect same cycle as EX; pc changes next edge; new BTB state visible next cycle.

Test Plan:
- Reset, RESET_PC=0, no EX traffic, 4 clocks → pc 0,4,8,12; pred_taken=0. Assert rst mid-run → pc=0 immediately, no clk edge needed.
- EX beq at 0x40, offset=3, rs=rt=5, ex_pred_taken=0 → redirect=1, redirect_pc=0x50, pc=0x50 next edge, mispred_cnt=1. pc=0x40 later → pred_taken=1, pred_target=0x50.
- Same beq trained to ctr=11: resolve not-taken twice → ctr 10 then 01. pc=0x40 → pred_taken=0.
- bltz with rs=0xFFFF_FFFF → taken. bgtz with rs=0 → not taken. bltz with rs=0x8000_0000 → taken.
- jr at 0x100, rs=0x2000, ex_pred_taken=1, ex_pred_target=0x1FFC → redirect=1, redirect_pc=0x2000. Same cycle stall=1 → pc still loads 0x2000.
- BTB alias at DEPTH=16: train 0x40, then taken jump at 0x80 → index 0 entry retagged. 0x40 lookup → pred_taken=0. mispred_cnt preset near max → stays 32'hFFFF_FFFF.
